// File: rtl/icache_fill_ctrl.sv
// ---------------------------------------------------------------------------
// icache_fill_ctrl
//
// Instruction-cache miss/refill controller. On a fetch miss it latches the
// line base address, streams LINE_WORDS words from memory into the cache data
// array, then returns to IDLE so the retried fetch can hit. A memory that
// stops answering for TIMEOUT consecutive cycles parks the block in a sticky
// error state until reset.
//
// Parameters
//   LINE_WORDS  words per cache line (power of two, 2..16)
//   TIMEOUT     consecutive FILL cycles without mem_ready before ERR
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   pc                  byte address of the instruction being fetched
//   fetch_req           fetch stage requests an instruction this cycle
//   cache_hit           tag match for pc this cycle
//   flush               redirect; discards the current fetch (IDLE only)
//   mem_ready           memory presents a valid word on mem_rdata
//   mem_rdata           refill data word
//   hit                 IF/ID capture strobe (combinational)
//   stall               freeze PC and fetch stage
//   mem_req, mem_addr   memory read request and word byte address
//   refill_we           cache data array write strobe
//   refill_addr/_data   cache data array write address / word
//   err                 sticky memory-timeout error
//   miss_cnt            saturating count of misses serviced
//   dbg_state           current FSM state (0 IDLE, 1 FILL, 2 DONE, 3 ERR)
//
// Memory handshake: while mem_req is high the block holds mem_addr steady;
// a word transfers on every cycle where mem_req and mem_ready are both high,
// and mem_addr advances to the next word on the following cycle. mem_ready
// outside FILL is ignored.
// ---------------------------------------------------------------------------
module icache_fill_ctrl #(
    parameter int LINE_WORDS = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc,
    input  logic        fetch_req,
    input  logic        cache_hit,
    input  logic        flush,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        hit,
    output logic        stall,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic        refill_we,
    output logic [31:0] refill_addr,
    output logic [31:0] refill_data,
    output logic        err,
    output logic [15:0] miss_cnt,
    output logic [1:0]  dbg_state
);

    localparam int WCW = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
    localparam int TW  = $clog2(TIMEOUT + 1);

    // Clears the word and byte offset bits of pc to give the line base.
    localparam logic [31:0] LINE_MASK = ~(32'(LINE_WORDS * 4) - 32'd1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_DONE = 2'd2,
        ST_ERR  = 2'd3
    } state_t;

    state_t          state;
    logic [WCW-1:0]  word_cnt;
    logic [TW-1:0]   tmo_cnt;
    logic [31:0]     mem_addr_q;
    logic [31:0]     refill_addr_q;
    logic [31:0]     refill_data_q;
    logic            err_q;
    logic [15:0]     miss_cnt_q;

    logic            in_idle;
    logic            in_fill;
    logic            miss_start;
    logic            last_word;
    logic            word_xfer;

    assign in_idle    = (state == ST_IDLE);
    assign in_fill    = (state == ST_FILL);
    assign miss_start = in_idle & fetch_req & ~cache_hit & ~flush;
    assign last_word  = (word_cnt == WCW'(LINE_WORDS - 1));
    assign word_xfer  = in_fill & mem_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            word_cnt      <= '0;
            tmo_cnt       <= '0;
            mem_addr_q    <= '0;
            refill_addr_q <= '0;
            refill_data_q <= '0;
            err_q         <= 1'b0;
            miss_cnt_q    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (miss_start) begin
                        state      <= ST_FILL;
                        mem_addr_q <= pc & LINE_MASK;
                        word_cnt   <= '0;
                        tmo_cnt    <= '0;
                    end
                end
                ST_FILL: begin
                    // flush is deliberately not looked at here: the line
                    // always completes once the refill has started.
                    if (mem_ready) begin
                        refill_addr_q <= mem_addr_q;
                        refill_data_q <= mem_rdata;
                        tmo_cnt       <= '0;
                        // Power-of-two line size: the increment wraps to 0
                        // on the last word by itself.
                        word_cnt      <= word_cnt + WCW'(1);
                        if (last_word) begin
                            state <= ST_DONE;
                            if (miss_cnt_q != 16'hFFFF) begin
                                miss_cnt_q <= miss_cnt_q + 16'd1;
                            end
                        end else begin
                            mem_addr_q <= mem_addr_q + 32'd4;
                        end
                    end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
                        state <= ST_ERR;
                        err_q <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                ST_ERR: begin
                    state <= ST_ERR;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // hit must be valid well before the negedge that loads IF/ID, so it is
    // decoded directly from the current state and inputs.
    assign hit         = in_idle & fetch_req & cache_hit & ~flush;
    assign stall       = ~in_idle | miss_start;
    assign mem_req     = in_fill;
    assign mem_addr    = mem_addr_q;
    assign refill_we   = word_xfer;
    // Write address/data follow the live transfer, otherwise hold the last
    // written word.
    assign refill_addr = word_xfer ? mem_addr_q : refill_addr_q;
    assign refill_data = word_xfer ? mem_rdata  : refill_data_q;
    assign err         = err_q;
    assign miss_cnt    = miss_cnt_q;
    assign dbg_state   = state;

endmodule

// File: tb/tb_icache_fill_ctrl.sv
module tb_icache_fill_ctrl;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_FILL = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [1:0] S_ERR  = 2'd3;

    logic        clk;
    logic        rst_n;
    logic [31:0] pc;
    logic        fetch_req;
    logic        cache_hit;
    logic        flush;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        hit;
    logic        stall;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        refill_we;
    logic [31:0] refill_addr;
    logic [31:0] refill_data;
    logic        err;
    logic [15:0] miss_cnt;
    logic [1:0]  dbg_state;

    int checks   = 0;
    int failures = 0;

    // Expected refill write addresses, in order.
    logic [31:0] exp_q[$];

    icache_fill_ctrl #(
        .LINE_WORDS(4),
        .TIMEOUT   (255)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pc         (pc),
        .fetch_req  (fetch_req),
        .cache_hit  (cache_hit),
        .flush      (flush),
        .mem_ready  (mem_ready),
        .mem_rdata  (mem_rdata),
        .hit        (hit),
        .stall      (stall),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .refill_we  (refill_we),
        .refill_addr(refill_addr),
        .refill_data(refill_data),
        .err        (err),
        .miss_cnt   (miss_cnt),
        .dbg_state  (dbg_state)
    );

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_line(input logic [31:0] base);
        for (int i = 0; i < 4; i++) exp_q.push_back(base + 32'(4 * i));
    endtask

    // Scoreboard: every refill write must match the next expected address.
    task automatic sb_refill(input string tag);
        logic [31:0] e;
        check({tag, "_q_nonempty"}, 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check({tag, "_refill_addr"}, refill_addr, e);
        end
    endtask

    initial begin
        int stall_cycles;
        int c;
        int words;
        int pulses;
        int n;

        pc = '0; fetch_req = 0; cache_hit = 0; flush = 0;
        mem_ready = 0; mem_rdata = '0; rst_n = 0;

        // Reset state
        #3;
        check("rst_state", 32'(dbg_state), 32'(S_IDLE));
        check("rst_err", 32'(err), 32'd0);
        check("rst_miss_cnt", 32'(miss_cnt), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_refill_addr", refill_addr, 32'd0);
        check("rst_refill_data", refill_data, 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        #24 rst_n = 1;
        tick();

        // Hit path
        pc = 32'h100; fetch_req = 1; cache_hit = 1;
        settle();
        check("hit_hit", 32'(hit), 32'd1);
        check("hit_stall", 32'(stall), 32'd0);
        check("hit_mem_req", 32'(mem_req), 32'd0);
        tick();
        check("hit_state", 32'(dbg_state), 32'(S_IDLE));

        // Miss with mem_ready always high
        pc = 32'h1238; cache_hit = 0;
        settle();
        check("miss1_req_stall", 32'(stall), 32'd1);
        check("miss1_req_hit", 32'(hit), 32'd0);
        push_line(32'h1230);
        tick();
        fetch_req = 0; mem_ready = 1; stall_cycles = 0;
        for (int i = 0; i < 4; i++) begin
            mem_rdata = 32'hA000_0000 + 32'(i);
            settle();
            check("miss1_state", 32'(dbg_state), 32'(S_FILL));
            check("miss1_mem_req", 32'(mem_req), 32'd1);
            check("miss1_mem_addr", mem_addr, 32'h1230 + 32'(4 * i));
            check("miss1_we", 32'(refill_we), 32'd1);
            check("miss1_data", refill_data, 32'hA000_0000 + 32'(i));
            sb_refill("miss1");
            if (stall) stall_cycles++;
            tick();
        end
        mem_ready = 0; fetch_req = 1; cache_hit = 1;
        settle();
        check("done_state", 32'(dbg_state), 32'(S_DONE));
        check("done_stall", 32'(stall), 32'd1);
        check("done_mem_req", 32'(mem_req), 32'd0);
        check("done_hit", 32'(hit), 32'd0);
        check("done_we", 32'(refill_we), 32'd0);
        check("done_mem_addr_hold", mem_addr, 32'h123C);
        check("done_data_hold", refill_data, 32'hA000_0003);
        check("done_miss_cnt", 32'(miss_cnt), 32'd1);
        if (stall) stall_cycles++;
        tick();
        settle();
        check("after_hit", 32'(hit), 32'd1);
        check("after_stall", 32'(stall), 32'd0);
        check("miss1_stall_cycles", 32'(stall_cycles), 32'd5);

        // Miss with mem_ready toggling 1,0,1,0...
        pc = 32'h2004; cache_hit = 0;
        push_line(32'h2000);
        tick();
        fetch_req = 0; c = 0; words = 0; pulses = 0;
        while (dbg_state == S_FILL && c < 20) begin
            mem_ready = (c % 2 == 0);
            mem_rdata = 32'hB000_0000 + 32'(c);
            settle();
            check("tog_mem_addr", mem_addr, 32'h2000 + 32'(4 * words));
            check("tog_we", 32'(refill_we), 32'(mem_ready));
            if (refill_we) begin
                pulses++;
                words++;
                sb_refill("tog");
            end
            tick();
            c++;
        end
        check("tog_pulses", 32'(pulses), 32'd4);
        check("tog_fill_cycles", 32'(c), 32'd7);
        check("tog_state", 32'(dbg_state), 32'(S_DONE));
        check("tog_err", 32'(err), 32'd0);
        check("tog_miss_cnt", 32'(miss_cnt), 32'd2);
        mem_ready = 0;
        tick();

        // Flush in IDLE blocks the miss and the hit
        fetch_req = 1; cache_hit = 0; flush = 1;
        settle();
        check("flush_idle_stall", 32'(stall), 32'd0);
        check("flush_idle_hit", 32'(hit), 32'd0);
        tick();
        check("flush_idle_state", 32'(dbg_state), 32'(S_IDLE));
        check("flush_idle_mem_req", 32'(mem_req), 32'd0);
        cache_hit = 1;
        settle();
        check("flush_idle_hit_blocked", 32'(hit), 32'd0);

        // Flush during FILL is ignored
        flush = 0; cache_hit = 0; pc = 32'h3010;
        push_line(32'h3010);
        tick();
        check("flush_fill_state", 32'(dbg_state), 32'(S_FILL));
        flush = 1; fetch_req = 0; mem_ready = 1;
        for (int i = 0; i < 4; i++) begin
            mem_rdata = 32'hC000_0000 + 32'(i);
            settle();
            check("flush_fill_we", 32'(refill_we), 32'd1);
            sb_refill("flush_fill");
            tick();
        end
        check("flush_fill_done", 32'(dbg_state), 32'(S_DONE));
        check("flush_fill_miss_cnt", 32'(miss_cnt), 32'd3);
        flush = 0; mem_ready = 0;
        tick();

        // Asynchronous reset during word 2 of a refill
        fetch_req = 1; pc = 32'h4000;
        tick();
        fetch_req = 0; mem_ready = 1; mem_rdata = 32'hD000_0000;
        tick();
        tick();
        settle();
        check("rstfill_addr_w2", mem_addr, 32'h4008);
        check("rstfill_we_w2", 32'(refill_we), 32'd1);
        #1 rst_n = 0;
        #1;
        check("rstfill_state", 32'(dbg_state), 32'(S_IDLE));
        check("rstfill_mem_req", 32'(mem_req), 32'd0);
        check("rstfill_we", 32'(refill_we), 32'd0);
        check("rstfill_miss_cnt", 32'(miss_cnt), 32'd0);
        check("rstfill_mem_addr", mem_addr, 32'd0);
        check("rstfill_refill_addr", refill_addr, 32'd0);
        mem_ready = 0;
        #1 rst_n = 1;
        tick();
        check("rstfill_after_state", 32'(dbg_state), 32'(S_IDLE));
        check("rstfill_after_stall", 32'(stall), 32'd0);

        // Timeout with mem_ready held low
        fetch_req = 1; cache_hit = 0; pc = 32'h5000;
        tick();
        fetch_req = 0; mem_ready = 0; n = 0;
        while (dbg_state == S_FILL && n < 300) begin
            n++;
            tick();
        end
        check("tmo_fill_cycles", 32'(n), 32'd255);
        check("tmo_state", 32'(dbg_state), 32'(S_ERR));
        check("tmo_err", 32'(err), 32'd1);
        check("tmo_stall", 32'(stall), 32'd1);
        check("tmo_mem_req", 32'(mem_req), 32'd0);
        fetch_req = 1; cache_hit = 1;
        settle();
        check("tmo_hit", 32'(hit), 32'd0);
        tick();
        tick();
        check("tmo_sticky_state", 32'(dbg_state), 32'(S_ERR));
        check("tmo_sticky_err", 32'(err), 32'd1);
        rst_n = 0;
        #1;
        check("tmo_rst_err", 32'(err), 32'd0);
        check("tmo_rst_state", 32'(dbg_state), 32'(S_IDLE));
        rst_n = 1;
        fetch_req = 0; cache_hit = 0;

        check("sb_drained", 32'(exp_q.size()), 32'd0);

        // Final report
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
